// File: rtl/uart_pkg.sv
// Purpose: shared UART types, constants and rate helper for the rx (and later tx) blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Receiver states; kept to 3 bits so the state register stays narrow.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Cycles-per-bit minus one; clk_fre is in MHz, uart_rate in bit/s.
    function automatic int calc_rate_cnt(input int clk_fre, input int uart_rate);
        return (clk_fre * 1_000_000 / uart_rate) - 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Purpose: N-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: STAGES clk cycles from d_i to q_o.
// Backpressure: none; a plain level follower.
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    if (STAGES < 2) begin : g_bad_stages
        $error("uart_sync needs at least 2 stages");
    end

    // Shift the raw input through the flop chain; reset to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with start-glitch rejection, framing-error and break handling.
// Latency: recv_valid about 9.5 bit times + 3 clk after the start edge on rx_pin.
// Backpressure: none; recv_valid/frame_err are single-cycle pulses the consumer must take.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic                 recv_valid,
    output logic [DATA_BITS-1:0] recv_data,
    output logic                 recv_busy,
    output logic                 frame_err
);

    localparam int RATE_CNT = calc_rate_cnt(CLK_FRE, UART_RATE);
    localparam int HALF_CNT = RATE_CNT / 2;

    localparam logic [25:0] RATE_CNT_W = 26'(RATE_CNT);
    localparam logic [25:0] HALF_CNT_W = 26'(HALF_CNT);
    localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

    if (RATE_CNT < 3) begin : g_bad_rate
        $error("uart_rx: RATE_CNT must be at least 3");
    end

    logic                 rx_s;
    logic                 rx_d_q;
    rx_state_e            state_q;
    logic [25:0]          clk_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] recv_data_q;
    logic                 recv_valid_q;
    logic                 frame_err_q;
    logic                 recv_busy_q;

    uart_sync #(
        .STAGES  (2),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_pin),
        .q_o   (rx_s)
    );

    // One extra flop behind the synchronizer for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_d_q <= 1'b1;
        end else begin
            rx_d_q <= rx_s;
        end
    end

    // Receive FSM: mid-bit sampling, byte assembly and registered output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            recv_data_q  <= '0;
            recv_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            recv_busy_q  <= 1'b0;
        end else begin
            recv_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_d_q && !rx_s) begin
                        clk_cnt_q   <= '0;
                        state_q     <= RX_START;
                        recv_busy_q <= 1'b1;
                    end
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_CNT_W) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            bit_cnt_q <= '0;
                            state_q   <= RX_DATA;
                        end else begin
                            // Line went back high before mid-start: a glitch, not a frame.
                            state_q     <= RX_IDLE;
                            recv_busy_q <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 26'd1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == RATE_CNT_W) begin
                        shift_q[bit_cnt_q] <= rx_s;
                        clk_cnt_q          <= '0;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 26'd1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == RATE_CNT_W) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            // Leave at mid-stop so a back-to-back start edge is not missed.
                            recv_data_q  <= shift_q;
                            recv_valid_q <= 1'b1;
                            state_q      <= RX_IDLE;
                            recv_busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= RX_BREAK;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 26'd1;
                    end
                end
                RX_BREAK: begin
                    // Hold off start detection until the line has returned high.
                    if (rx_s) begin
                        state_q     <= RX_IDLE;
                        recv_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= RX_IDLE;
                    clk_cnt_q   <= '0;
                    recv_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign recv_valid = recv_valid_q;
    assign recv_data  = recv_data_q;
    assign recv_busy  = recv_busy_q;
    assign frame_err  = frame_err_q;

endmodule
